// File: rtl/mux_nto1_rr_reg.sv
// mux_nto1_rr_reg: N-channel registered mux with valid/ready handshakes, fixed-select or round-robin grant
module mux_nto1_rr_reg #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N*W-1:0]  IN_DATA,
  input  logic [N-1:0]    IN_VALID,
  output logic [N-1:0]    IN_READY,
  input  logic [SW-1:0]   SEL,
  input  logic            MODE,
  output logic [W-1:0]    OUT_DATA,
  output logic [SW-1:0]   OUT_CH,
  output logic            OUT_VALID,
  input  logic            OUT_READY
);
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] w_g;
  logic          w_gv;
  logic          w_load;
  logic          w_xfer;
  assign w_load = !OUT_VALID || OUT_READY;
  assign w_xfer = RST_N && w_load && w_gv;
  // grant: fixed channel SEL, or first valid channel scanning upward from r_ptr with wrap
  always_comb begin
    w_gv = 1'b0;
    w_g  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (MODE && IN_VALID[(int'(r_ptr) + k) % N]) begin
        w_gv = 1'b1;
        w_g  = SW'((int'(r_ptr) + k) % N);
      end
      if (!MODE && int'(SEL) == k && IN_VALID[k]) begin
        w_gv = 1'b1;
        w_g  = SW'(k);
      end
    end
  end
  // accept only on the granted channel, and only when the output register can take a word
  always_comb begin
    IN_READY = '0;
    for (int i = 0; i < N; i++)
      IN_READY[i] = w_xfer && (int'(w_g) == i);
  end
  // output register and round-robin pointer; pointer follows the last served channel in both modes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_DATA  <= '0;
      OUT_CH    <= '0;
      OUT_VALID <= 1'b0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      OUT_DATA  <= IN_DATA[int'(w_g)*W +: W];
      OUT_CH    <= w_g;
      OUT_VALID <= 1'b1;
      r_ptr     <= (int'(w_g) == N - 1) ? '0 : w_g + 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// tb_mux_nto1_rr_reg: scoreboard bench with a queue-based reference model for the registered N-to-1 mux
module tb_mux_nto1_rr_reg;
  localparam int N = 4, W = 8, SW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0, in_ready;
  logic [SW-1:0] sel = '0, out_ch;
  logic mode = 1'b0, out_ready = 1'b0, out_valid;
  logic [W-1:0] out_data;
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0] in_valid3 = '0, in_ready3;
  logic [1:0] sel3 = '0, out_ch3;
  logic mode3 = 1'b0, out_ready3 = 1'b1, out_valid3;
  logic [W-1:0] out_data3;
  int tests = 0, fails = 0;
  int m_ptr = 0;
  bit m_occ = 0;
  typedef struct { logic [W-1:0] d; int ch; } item_t;
  item_t q[$];

  mux_nto1_rr_reg #(.N(N), .W(W)) u_dut (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SEL(sel), .MODE(mode), .OUT_DATA(out_data), .OUT_CH(out_ch), .OUT_VALID(out_valid),
    .OUT_READY(out_ready));

  mux_nto1_rr_reg #(.N(3), .W(W)) u_dut3 (
    .CLK(clk), .RST_N(rst_n), .IN_DATA(in_data3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
    .SEL(sel3), .MODE(mode3), .OUT_DATA(out_data3), .OUT_CH(out_ch3), .OUT_VALID(out_valid3),
    .OUT_READY(out_ready3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference grant: fixed channel, or the valid channel at the smallest forward distance from the pointer
  function automatic int ref_grant();
    int best = -1, bestd = N;
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int c = 0; c < N; c++)
      if (in_valid[c] && (c - m_ptr + N) % N < bestd) begin
        best = c;
        bestd = (c - m_ptr + N) % N;
      end
    return best;
  endfunction

  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [SW-1:0] s,
                      input bit md, input bit ordy);
    int g;
    bit load;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    in_valid = v; in_data = d; sel = s; mode = md; out_ready = ordy;
    #1;
    g = ref_grant();
    load = !m_occ || ordy;
    exp_rdy = (load && g >= 0) ? N'(1 << g) : '0;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_occ);
    if (load && g >= 0) begin
      q.push_back('{d[g*W +: W], g});
      m_occ = 1;
      m_ptr = (g + 1) % N;
    end else if (ordy) m_occ = 0;
  endtask

  // monitor: every word the consumer takes must be the oldest expected one
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        item_t it;
        it = q.pop_front();
        chk("out_data", out_data, it.d);
        chk("out_ch", out_ch, it.ch);
      end
    end
  end

  localparam logic [N*W-1:0] D = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step('0, D, '0, 0, 1);
      chk("idle_out_data", out_data, 0);
    end
    // fixed select
    step(4'hF, D, 2'd2, 0, 1);
    step(4'hF, D, 2'd0, 0, 1);
    step(4'h0, D, 2'd0, 0, 1);
    // N=3 instance: SEL beyond the channel count grants nothing
    @(negedge clk);
    in_data3 = {8'h66, 8'h55, 8'h77}; in_valid3 = 3'b111; sel3 = 2'd1;
    @(negedge clk);
    sel3 = 2'd3;
    #1;
    chk("n3_out_valid", out_valid3, 1);
    chk("n3_out_data", out_data3, 8'h55);
    chk("n3_in_ready", in_ready3, 0);
    @(negedge clk); #1;
    chk("n3_out_valid_fall", out_valid3, 0);
    in_valid3 = '0;
    // async reset while holding a word
    step(4'hF, D, 2'd3, 0, 0);
    step(4'h0, D, 2'd0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", out_valid, 0);
    chk("areset_out_data", out_data, 0);
    chk("areset_in_ready", in_ready, 0);
    q.delete(); m_occ = 0; m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // round robin, all valid: expect 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) step(4'hF, D, 2'd0, 1, 1);
    step(4'h0, D, 2'd0, 1, 1);
    // put pointer at 2 then only ch1/ch3 valid: ch3, ch1, ch3
    step(4'b0010, D, 2'd1, 0, 1);
    for (int i = 0; i < 3; i++) step(4'b1010, D, 2'd0, 1, 1);
    step(4'h0, D, 2'd0, 1, 1);
    // backpressure with A5 held
    step(4'h1, {8'h44, 8'h33, 8'h22, 8'hA5}, 2'd0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(4'hF, D, 2'd0, 1, 0);
      chk("stall_out_data", out_data, 8'hA5);
    end
    step(4'hF, D, 2'd0, 1, 1);
    step(4'hF, D, 2'd0, 1, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(N'($urandom), {$urandom}, SW'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) step('0, D, '0, 0, 1);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
